writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter ADDR_SIZE, default 5, register-file address width.
REQ-002 Parameter WORD_SIZE, default 32, datapath width; SHALL equal 8*2^OFF_SIZE and be at least 32.
REQ-003 Parameter OFF_SIZE, default 2, byte-offset width within a word.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  mem stage presents a writeback transaction.
- in_ready  out  1  unit accepts a transaction this cycle.
- in_we  in  1  transaction writes the register file.
- in_addr  in  ADDR_SIZE  destination register.
- in_sel  in  2  source: 0 ALU, 1 memory, 2 link, 3 treated as ALU.
- in_alu_data  in  WORD_SIZE  ALU result.
- in_link_data  in  WORD_SIZE  return address for link instructions.
- in_size  in  2  load size: 0 byte, 1 half, 2 word32, 3 full WORD_SIZE.
- in_signed  in  1  sign-extend the extracted load.
- in_offset  in  OFF_SIZE  load byte offset.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  WORD_SIZE  load data.
- flush  in  1  kill pending or presented transaction.
- busy  out  1  high in WAIT.
- reg_d_we  out  1  registered one-cycle write strobe.
- reg_d_addr  out  ADDR_SIZE  registered write address.
- reg_d_data  out  WORD_SIZE  registered write data.

Function
REQ-005 FSM states SHALL be IDLE and WAIT; in_ready = (state==IDLE); busy = (state==WAIT).
REQ-006 Accept SHALL occur on in_valid && in_ready && !flush; in_we, in_addr, in_size, in_signed and in_offset SHALL be captured on accept.
REQ-007 Accept with in_sel != 1: the next edge SHALL drive reg_d_we=in_we&&(in_addr!=0), reg_d_addr=in_addr, reg_d_data=in_alu_data (sel 0/3) or in_link_data (sel 2); state stays IDLE; latency 1 cycle.
REQ-008 Accept with in_sel == 1 SHALL move to WAIT with no write issued.
REQ-009 In WAIT, mem_rvalid && !flush: the next edge SHALL issue the write from the captured fields with extracted load data and return to IDLE.
REQ-010 mem_rvalid in IDLE SHALL be ignored; WAIT SHALL persist indefinitely until mem_rvalid or flush.
REQ-011 Extraction: byte = bits [8*off+7:8*off]; half uses off with bit 0 cleared; word32 uses off with bits [1:0] cleared; full = mem_rdata unchanged.
REQ-012 Extracted byte, half and word32 values SHALL be zero-extended to WORD_SIZE, or sign-extended when the captured in_signed is 1; word32 extension SHALL be a no-op when WORD_SIZE==32.
REQ-013 A write to address 0 SHALL be suppressed: reg_d_we=0, while reg_d_addr and reg_d_data still update.
REQ-014 reg_d_we SHALL be high for exactly one cycle per write; reg_d_addr and reg_d_data SHALL hold their last values otherwise.
REQ-015 flush priority: flush in IDLE SHALL drop the presented transaction; flush in WAIT SHALL return to IDLE with no write, including when mem_rvalid is high in the same cycle.
REQ-016 Back-to-back non-memory accepts SHALL produce writes on consecutive cycles with no bubble.

Reset
REQ-017 rst_n low SHALL immediately force state IDLE and reg_d_we=0, reg_d_addr=0, reg_d_data=0, and all captured fields to 0, without waiting for clk.
REQ-018 A reset asserted in WAIT SHALL discard the pending load; mem_rvalid arriving after reset release SHALL produce no write.

Verification
REQ-019 ALU write: sel=0, we=1, addr=5, alu=0x12345678 -> next cycle reg_d_we=1, addr=5, data=0x12345678; the following cycle reg_d_we=0.
REQ-020 Signed byte load: sel=1, size=0, signed=1, off=3, addr=8; rvalid two cycles later with rdata=0x80FF0011 -> busy for 2 cycles, then a single write of 0xFFFFFF80 to reg 8; in_ready low during WAIT.
REQ-021 Unsigned half load: off=2, rdata=0xBEEF1234 -> data=0x0000BEEF; signed half with the same inputs -> 0xFFFFBEEF.
REQ-022 Zero register: sel=2, we=1, addr=0, link=0x00400008 -> reg_d_we stays 0, reg_d_data=0x00400008.
REQ-023 Flush race: load accepted, then flush and rvalid in the same WAIT cycle -> no write, state IDLE, in_ready=1 next cycle.
REQ-024 Async reset in WAIT: rst_n pulsed low mid-cycle -> outputs 0 before the next edge; a later rvalid produces no write.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. It takes a mem-stage result and
// writes it to the register file. ALU and link results write the next
// cycle. Loads wait for mem_rvalid, then extract and extend the load data.
// Ports:
//   clk, rst_n            clock and async active-low reset
//   in_valid/in_ready     transaction handshake from the mem stage
//   in_we, in_addr        write enable and destination register
//   in_sel                source select: ALU, memory, link (3 = ALU)
//   in_alu_data           ALU result
//   in_link_data          return address for link instructions
//   in_size, in_signed    load size and sign-extension flag
//   in_offset             load byte offset
//   mem_rvalid, mem_rdata load data return
//   flush                 kills a presented or pending transaction
//   busy                  high while waiting for load data
//   reg_d_*               registered register-file write port
module writeback_unit #(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int OFF_SIZE  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_we,
   input  logic [ADDR_SIZE-1:0] in_addr,
   input  logic [1:0]           in_sel,
   input  logic [WORD_SIZE-1:0] in_alu_data,
   input  logic [WORD_SIZE-1:0] in_link_data,
   input  logic [1:0]           in_size,
   input  logic                 in_signed,
   input  logic [OFF_SIZE-1:0]  in_offset,
   input  logic                 mem_rvalid,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 flush,
   output logic                 busy,
   output logic                 reg_d_we,
   output logic [ADDR_SIZE-1:0] reg_d_addr,
   output logic [WORD_SIZE-1:0] reg_d_data
);

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   localparam logic [OFF_SIZE-1:0] H_MASK = ~OFF_SIZE'(1);
   localparam logic [OFF_SIZE-1:0] W_MASK = ~OFF_SIZE'(3);

   state_t state;
   state_t state_nx;

   logic                 accept;
   logic                 wr_go;
   logic                 wr_we;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [WORD_SIZE-1:0] wr_data;

   logic                 cap_we;
   logic [ADDR_SIZE-1:0] cap_addr;
   logic [1:0]           cap_size;
   logic                 cap_signed;
   logic [OFF_SIZE-1:0]  cap_off;

   logic [OFF_SIZE+2:0]  sh_b;
   logic [OFF_SIZE+2:0]  sh_h;
   logic [OFF_SIZE+2:0]  sh_w;
   logic [7:0]           ld_b;
   logic [15:0]          ld_h;
   logic [31:0]          ld_w;
   logic [WORD_SIZE-1:0] ld_data;

   assign in_ready = (state == IDLE);
   assign busy     = (state == WAIT);
   assign accept   = in_valid && in_ready && !flush;

   // Half and word32 accesses are naturally aligned: low offset
   // bits are dropped before forming the shift.
   always_comb begin
      sh_b = {cap_off, 3'b000};
      sh_h = {cap_off & H_MASK, 3'b000};
      sh_w = {cap_off & W_MASK, 3'b000};
      ld_b = 8'(mem_rdata >> sh_b);
      ld_h = 16'(mem_rdata >> sh_h);
      ld_w = 32'(mem_rdata >> sh_w);
      ld_data = mem_rdata;
      unique case (cap_size)
         2'd0: begin
            ld_data = WORD_SIZE'(ld_b);
            if (cap_signed && ld_b[7])
               ld_data = ld_data | ~WORD_SIZE'(8'hFF);
         end
         2'd1: begin
            ld_data = WORD_SIZE'(ld_h);
            if (cap_signed && ld_h[15])
               ld_data = ld_data | ~WORD_SIZE'(16'hFFFF);
         end
         2'd2: begin
            // upper mask is empty when WORD_SIZE is 32
            ld_data = WORD_SIZE'(ld_w);
            if (cap_signed && ld_w[31])
               ld_data = ld_data | ~WORD_SIZE'(32'hFFFF_FFFF);
         end
         2'd3: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      wr_go    = 1'b0;
      wr_we    = 1'b0;
      wr_addr  = in_addr;
      wr_data  = in_alu_data;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (in_sel == 2'd1) begin
                  state_nx = WAIT;
               end else begin
                  wr_go = 1'b1;
                  wr_we = in_we && (in_addr != '0);
                  if (in_sel == 2'd2)
                     wr_data = in_link_data;
               end
            end
         end
         WAIT: begin
            // flush wins over a same-cycle rvalid
            if (flush) begin
               state_nx = IDLE;
            end else if (mem_rvalid) begin
               state_nx = IDLE;
               wr_go    = 1'b1;
               wr_we    = cap_we && (cap_addr != '0);
               wr_addr  = cap_addr;
               wr_data  = ld_data;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we     <= 1'b0;
         cap_addr   <= '0;
         cap_size   <= '0;
         cap_signed <= 1'b0;
         cap_off    <= '0;
      end else if (accept) begin
         cap_we     <= in_we;
         cap_addr   <= in_addr;
         cap_size   <= in_size;
         cap_signed <= in_signed;
         cap_off    <= in_offset;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_d_we   <= 1'b0;
         reg_d_addr <= '0;
         reg_d_data <= '0;
      end else begin
         reg_d_we <= wr_go && wr_we;
         if (wr_go) begin
            reg_d_addr <= wr_addr;
            reg_d_data <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit.
// Expected writes are queued at drive time and popped on reg_d_we.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_we = 1'b0;
   logic [4:0]  in_addr = '0;
   logic [1:0]  in_sel = '0;
   logic [31:0] in_alu_data = '0;
   logic [31:0] in_link_data = '0;
   logic [1:0]  in_size = '0;
   logic        in_signed = 1'b0;
   logic [1:0]  in_offset = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        reg_d_we;
   logic [4:0]  reg_d_addr;
   logic [31:0] reg_d_data;

   int n_chk = 0;
   int n_err = 0;
   logic [36:0] sb_q[$];

   writeback_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_we        (in_we),
      .in_addr      (in_addr),
      .in_sel       (in_sel),
      .in_alu_data  (in_alu_data),
      .in_link_data (in_link_data),
      .in_size      (in_size),
      .in_signed    (in_signed),
      .in_offset    (in_offset),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .flush        (flush),
      .busy         (busy),
      .reg_d_we     (reg_d_we),
      .reg_d_addr   (reg_d_addr),
      .reg_d_data   (reg_d_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ld_model(
      input logic [1:0]  size,
      input logic        sgn,
      input logic [1:0]  off,
      input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*off +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'd0: ld_model = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'd1: ld_model = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: ld_model = rd;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && reg_d_we) begin
         if (sb_q.size() == 0) begin
            chk("unexp_we", {27'h0, reg_d_addr, reg_d_data}, 64'h0);
         end else begin
            logic [36:0] e;
            e = sb_q.pop_front();
            chk("wr_addr", 64'(reg_d_addr), 64'(e[36:32]));
            chk("wr_data", 64'(reg_d_data), 64'(e[31:0]));
         end
      end
   end

   task automatic send(input logic [1:0] sel, input logic we,
                       input logic [4:0] addr,
                       input logic [31:0] alu,
                       input logic [31:0] link);
      in_valid     = 1'b1;
      in_sel       = sel;
      in_we        = we;
      in_addr      = addr;
      in_alu_data  = alu;
      in_link_data = link;
      if (sel != 2'd1 && we && addr != 0)
         sb_q.push_back({addr, (sel == 2'd2) ? link : alu});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_ld(input logic [4:0] addr,
                          input logic [1:0] size,
                          input logic sgn,
                          input logic [1:0] off);
      in_size   = size;
      in_signed = sgn;
      in_offset = off;
      send(2'd1, 1'b1, addr, 32'hDEAD_0000, 32'h0);
   endtask

   task automatic rvalid(input logic [4:0] addr,
                         input logic [1:0] size,
                         input logic sgn,
                         input logic [1:0] off,
                         input logic [31:0] rd);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      if (addr != 0)
         sb_q.push_back({addr, ld_model(size, sgn, off, rd)});
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_we", 64'(reg_d_we), 64'h0);
      chk("rst_addr", 64'(reg_d_addr), 64'h0);
      chk("rst_data", 64'(reg_d_data), 64'h0);
      chk("rst_ready", 64'(in_ready), 64'h1);
      chk("rst_busy", 64'(busy), 64'h0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU write, one-cycle strobe
      send(2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0);
      chk("alu_we", 64'(reg_d_we), 64'h1);
      @(posedge clk);
      #1;
      chk("alu_pulse", 64'(reg_d_we), 64'h0);
      chk("alu_hold", 64'(reg_d_data), 64'h1234_5678);

      // rvalid in IDLE ignored
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      chk("idle_rv", 64'(reg_d_we), 64'h0);

      // signed byte load, two wait cycles
      send_ld(5'd8, 2'd0, 1'b1, 2'd3);
      chk("ld_busy0", 64'(busy), 64'h1);
      chk("ld_rdy0", 64'(in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("ld_busy1", 64'(busy), 64'h1);
      chk("ld_rdy1", 64'(in_ready), 64'h0);
      rvalid(5'd8, 2'd0, 1'b1, 2'd3, 32'h80FF_0011);
      chk("ld_done", 64'(busy), 64'h0);
      chk("sb_val", 64'(reg_d_data), 64'hFFFF_FF80);

      // half loads
      send_ld(5'd9, 2'd1, 1'b0, 2'd2);
      rvalid(5'd9, 2'd1, 1'b0, 2'd2, 32'hBEEF_1234);
      chk("uh_val", 64'(reg_d_data), 64'h0000_BEEF);
      send_ld(5'd10, 2'd1, 1'b1, 2'd2);
      rvalid(5'd10, 2'd1, 1'b1, 2'd2, 32'hBEEF_1234);
      chk("sh_val", 64'(reg_d_data), 64'hFFFF_BEEF);

      // random loads with random wait
      for (int i = 0; i < 12; i++) begin
         logic [4:0]  a;
         logic [1:0]  sz;
         logic        sg;
         logic [1:0]  of;
         logic [31:0] rd;
         a  = 5'($urandom_range(1, 31));
         sz = 2'($urandom);
         sg = 1'($urandom);
         of = 2'($urandom);
         rd = $urandom;
         send_ld(a, sz, sg, of);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         rvalid(a, sz, sg, of, rd);
      end

      // zero register suppressed
      send(2'd2, 1'b1, 5'd0, 32'h0, 32'h0040_0008);
      chk("z_we", 64'(reg_d_we), 64'h0);
      chk("z_data", 64'(reg_d_data), 64'h0040_0008);
      chk("z_addr", 64'(reg_d_addr), 64'h0);

      // we=0 updates data without strobe
      send(2'd0, 1'b0, 5'd7, 32'hCAFE_0001, 32'h0);
      chk("nowe_we", 64'(reg_d_we), 64'h0);
      chk("nowe_dat", 64'(reg_d_data), 64'hCAFE_0001);

      // back-to-back, sel 0/2/3
      in_valid = 1'b1;
      in_we    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] s;
         s = (i == 1) ? 2'd2 : ((i == 2) ? 2'd3 : 2'd0);
         in_sel       = s;
         in_addr      = 5'(i + 1);
         in_alu_data  = 32'hA000_0000 + 32'(i);
         in_link_data = 32'hB000_0000 + 32'(i);
         sb_q.push_back({5'(i + 1),
                         (s == 2'd2) ? in_link_data : in_alu_data});
         @(posedge clk);
         #1;
         chk("b2b_we", 64'(reg_d_we), 64'h1);
      end
      in_valid = 1'b0;

      // flush in IDLE drops transaction
      flush = 1'b1;
      send(2'd0, 1'b1, 5'd3, 32'h1111_1111, 32'h0);
      sb_q.delete(sb_q.size() - 1);
      flush = 1'b0;
      chk("fl_idle", 64'(reg_d_we), 64'h0);
      chk("fl_busy", 64'(busy), 64'h0);

      // flush races rvalid in WAIT
      send_ld(5'd12, 2'd2, 1'b0, 2'd0);
      flush      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      chk("race_we", 64'(reg_d_we), 64'h0);
      chk("race_rdy", 64'(in_ready), 64'h1);

      // async reset in WAIT
      send(2'd0, 1'b1, 5'd4, 32'h7777_0000, 32'h0);
      send_ld(5'd13, 2'd2, 1'b0, 2'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_data", 64'(reg_d_data), 64'h0);
      chk("ar_addr", 64'(reg_d_addr), 64'h0);
      chk("ar_busy", 64'(busy), 64'h0);
      chk("ar_rdy", 64'(in_ready), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_4321;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      chk("ar_nowr", 64'(reg_d_we), 64'h0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
